// File: rtl/snake_pkg.sv
// Shared snake-game constants, spawner state encoding and the spawner LFSR step function.
package snake_pkg;

    localparam int unsigned COORD_W    = 6;
    localparam int unsigned GRID_W     = 64;
    localparam int unsigned GRID_H     = 48;
    localparam int unsigned NUM_APPLES = 5;
    localparam int unsigned SLOT_W     = 3;
    localparam int unsigned LFSR_W     = 16;
    localparam int unsigned TRIES_W    = 8;

    // Galois taps for x^16+x^14+x^13+x^11+1 in right-shift form
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SPAWN_IDLE    = 2'd0,
        SPAWN_PROPOSE = 2'd1,
        SPAWN_CHECK   = 2'd2
    } spawn_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        lfsr_next = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// Free-running 16-bit Galois LFSR supplying candidate apple positions.
module spawn_lfsr
    import snake_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= SEED;
        end else begin
            r_value <= lfsr_next(r_value);
        end
    end

    assign value = r_value;

endmodule

// File: rtl/apple_spawner.sv
// Places an apple in a requested slot by probing random cells against the occupancy block.
// Optional APPLE_SPAWN_STATS_EN adds a wrapping 16-bit count of successful spawns.
module apple_spawner
    import snake_pkg::*;
#(
    parameter int unsigned       MAX_TRIES = 64,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          spawn_req,
    input  logic [SLOT_W-1:0]             spawn_slot,
    output logic [COORD_W-1:0]            q_x,
    output logic [COORD_W-1:0]            q_y,
    input  logic                          q_answer,
    output logic [COORD_W*NUM_APPLES-1:0] apple_x,
    output logic [COORD_W*NUM_APPLES-1:0] apple_y,
    output logic                          busy,
    output logic                          done,
    output logic                          fail
`ifdef APPLE_SPAWN_STATS_EN
    ,
    output logic [15:0]                   spawn_count
`endif
);

    localparam int unsigned          APPLES_W   = COORD_W * NUM_APPLES;
    localparam logic [SLOT_W-1:0]    SLOT_LIMIT = SLOT_W'(NUM_APPLES);
    localparam logic [TRIES_W-1:0]   TRIES_MAX  = TRIES_W'(MAX_TRIES);

    spawn_state_t          r_state;
    logic [SLOT_W-1:0]     r_slot;
    logic [TRIES_W-1:0]    r_tries;
    logic [COORD_W-1:0]    r_q_x;
    logic [COORD_W-1:0]    r_q_y;
    logic [APPLES_W-1:0]   r_apple_x;
    logic [APPLES_W-1:0]   r_apple_y;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_fail;
    logic [LFSR_W-1:0]     w_lfsr;
    logic [3:0]            w_unused_lfsr;

    spawn_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (w_lfsr)
    );

    // Top nibble of the LFSR is not part of any candidate coordinate
    assign w_unused_lfsr = w_lfsr[15:12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SPAWN_IDLE;
            r_slot    <= '0;
            r_tries   <= '0;
            r_q_x     <= '0;
            r_q_y     <= '0;
            r_apple_x <= '0;
            r_apple_y <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_fail <= 1'b0;
            case (r_state)
                SPAWN_IDLE: begin
                    if (spawn_req) begin
                        if (spawn_slot < SLOT_LIMIT) begin
                            r_slot  <= spawn_slot;
                            r_tries <= '0;
                            r_state <= SPAWN_PROPOSE;
                            r_busy  <= 1'b1;
                        end else begin
                            r_fail <= 1'b1;
                        end
                    end
                end
                SPAWN_PROPOSE: begin
                    r_q_x   <= w_lfsr[5:0];
                    r_q_y   <= w_lfsr[11:6];
                    if (r_tries != '1) begin
                        r_tries <= r_tries + 8'd1;
                    end
                    r_state <= SPAWN_CHECK;
                end
                SPAWN_CHECK: begin
                    // Range and self-collision rejection are left to the inquiry block
                    if (!q_answer) begin
                        r_apple_x[r_slot*COORD_W +: COORD_W] <= r_q_x;
                        r_apple_y[r_slot*COORD_W +: COORD_W] <= r_q_y;
                        r_done  <= 1'b1;
                        r_state <= SPAWN_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_tries >= TRIES_MAX) begin
                        r_fail  <= 1'b1;
                        r_state <= SPAWN_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= SPAWN_PROPOSE;
                    end
                end
                default: begin
                    r_state <= SPAWN_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef APPLE_SPAWN_STATS_EN
    logic [15:0] r_spawn_count;

    // Counts alongside the slot write so the total is current in the done cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spawn_count <= '0;
        end else if (r_state == SPAWN_CHECK && !q_answer) begin
            r_spawn_count <= r_spawn_count + 16'd1;
        end
    end

    assign spawn_count = r_spawn_count;
`endif

    assign q_x     = r_q_x;
    assign q_y     = r_q_y;
    assign apple_x = r_apple_x;
    assign apple_y = r_apple_y;
    assign busy    = r_busy;
    assign done    = r_done;
    assign fail    = r_fail;

endmodule

// File: tb/tb_apple_spawner.sv
// Directed bench for apple_spawner: reset, single/multi-try spawns, exhaustion, rejects, aborts.
module tb_apple_spawner;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk;
    logic        rst_n;
    logic        spawn_req;
    logic [2:0]  spawn_slot;
    logic [5:0]  q_x;
    logic [5:0]  q_y;
    logic        q_answer;
    logic [29:0] apple_x;
    logic [29:0] apple_y;
    logic        busy;
    logic        done;
    logic        fail;
`ifdef APPLE_SPAWN_STATS_EN
    logic [15:0] spawn_count;
`endif

    int n_cmp;
    int n_fail;
    logic [15:0] m_lfsr;
    logic [29:0] exp_ax;
    logic [29:0] exp_ay;

    apple_spawner #(
        .MAX_TRIES (4),
        .LFSR_SEED (SEED)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spawn_req  (spawn_req),
        .spawn_slot (spawn_slot),
        .q_x        (q_x),
        .q_y        (q_y),
        .q_answer   (q_answer),
        .apple_x    (apple_x),
        .apple_y    (apple_y),
        .busy       (busy),
        .done       (done),
        .fail       (fail)
`ifdef APPLE_SPAWN_STATS_EN
        ,
        .spawn_count(spawn_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR written directly from the polynomial x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] ref_step(input logic [15:0] v);
        logic       b;
        logic [15:0] n;
        b = v[0];
        n = {b, v[15:1]};
        n[13] = n[13] ^ b;
        n[12] = n[12] ^ b;
        n[10] = n[10] ^ b;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= ref_step(m_lfsr);
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        n_cmp++; if (apple_x !== 30'd0) begin n_fail++; $display("FAIL rst_apple_x: got %h want 0", apple_x); end
        n_cmp++; if (apple_y !== 30'd0) begin n_fail++; $display("FAIL rst_apple_y: got %h want 0", apple_y); end
        n_cmp++; if ({busy, done, fail} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {busy, done, fail}); end
        n_cmp++; if ({q_x, q_y} !== 12'd0) begin n_fail++; $display("FAIL rst_q: got %h want 0", {q_x, q_y}); end
        tick;
        n_cmp++; if ({busy, done, fail} !== 3'b000) begin n_fail++; $display("FAIL rst_idle: got %b want 000", {busy, done, fail}); end
    endtask

    // One-try success into the given slot; done expected in cycle 3
    task automatic do_success(input int slot);
        logic [5:0] cx, cy;
        spawn_req = 1'b1; spawn_slot = 3'(slot); q_answer = 1'b0;
        tick;
        spawn_req = 1'b0;
        cx = m_lfsr[5:0]; cy = m_lfsr[11:6];
        n_cmp++; if ({busy, done, fail} !== 3'b100) begin n_fail++; $display("FAIL succ_c1_flags: got %b want 100", {busy, done, fail}); end
        tick;
        n_cmp++; if ({busy, done, fail} !== 3'b100) begin n_fail++; $display("FAIL succ_c2_flags: got %b want 100", {busy, done, fail}); end
        n_cmp++; if ({q_x, q_y} !== {cx, cy}) begin n_fail++; $display("FAIL succ_c2_q: got %h want %h", {q_x, q_y}, {cx, cy}); end
        tick;
        exp_ax[slot*6 +: 6] = cx; exp_ay[slot*6 +: 6] = cy;
        n_cmp++; if ({busy, done, fail} !== 3'b010) begin n_fail++; $display("FAIL succ_c3_flags: got %b want 010", {busy, done, fail}); end
        n_cmp++; if ({apple_x, apple_y} !== {exp_ax, exp_ay}) begin n_fail++; $display("FAIL succ_apples: got %h/%h want %h/%h", apple_x, apple_y, exp_ax, exp_ay); end
    endtask

    task automatic test_single_try;
        do_success(2);
    endtask

    task automatic test_retry;
        logic [5:0] cx, cy;
        spawn_req = 1'b1; spawn_slot = 3'd0; q_answer = 1'b1;
        tick;
        spawn_req = 1'b0;
        repeat (4) tick;
        cx = m_lfsr[5:0]; cy = m_lfsr[11:6];
        n_cmp++; if ({busy, done, fail} !== 3'b100) begin n_fail++; $display("FAIL retry_c5_flags: got %b want 100", {busy, done, fail}); end
        tick;
        q_answer = 1'b0;
        n_cmp++; if ({q_x, q_y} !== {cx, cy}) begin n_fail++; $display("FAIL retry_c6_q: got %h want %h", {q_x, q_y}, {cx, cy}); end
        tick;
        exp_ax[5:0] = cx; exp_ay[5:0] = cy;
        n_cmp++; if ({busy, done, fail} !== 3'b010) begin n_fail++; $display("FAIL retry_c7_flags: got %b want 010", {busy, done, fail}); end
        n_cmp++; if ({apple_x, apple_y} !== {exp_ax, exp_ay}) begin n_fail++; $display("FAIL retry_apples: got %h/%h want %h/%h", apple_x, apple_y, exp_ax, exp_ay); end
    endtask

    task automatic test_exhaust;
        spawn_req = 1'b1; spawn_slot = 3'd1; q_answer = 1'b1;
        tick;
        spawn_req = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            n_cmp++; if ({busy, done, fail} !== 3'b100) begin n_fail++; $display("FAIL exh_c%0d_flags: got %b want 100", c, {busy, done, fail}); end
            tick;
        end
        n_cmp++; if ({busy, done, fail} !== 3'b001) begin n_fail++; $display("FAIL exh_c9_flags: got %b want 001", {busy, done, fail}); end
        n_cmp++; if ({apple_x, apple_y} !== {exp_ax, exp_ay}) begin n_fail++; $display("FAIL exh_apples: got %h/%h want %h/%h", apple_x, apple_y, exp_ax, exp_ay); end
        q_answer = 1'b0;
        tick;
        n_cmp++; if ({busy, done, fail} !== 3'b000) begin n_fail++; $display("FAIL exh_c10_flags: got %b want 000", {busy, done, fail}); end
    endtask

    task automatic test_bad_slot;
        spawn_req = 1'b1; spawn_slot = 3'd6;
        tick;
        spawn_req = 1'b0;
        n_cmp++; if ({busy, done, fail} !== 3'b001) begin n_fail++; $display("FAIL bad_c1_flags: got %b want 001", {busy, done, fail}); end
        tick;
        n_cmp++; if ({busy, done, fail} !== 3'b000) begin n_fail++; $display("FAIL bad_c2_flags: got %b want 000", {busy, done, fail}); end
        n_cmp++; if ({apple_x, apple_y} !== {exp_ax, exp_ay}) begin n_fail++; $display("FAIL bad_apples: got %h/%h want %h/%h", apple_x, apple_y, exp_ax, exp_ay); end
    endtask

    task automatic test_ignore_busy;
        logic [5:0] cx, cy;
        spawn_req = 1'b1; spawn_slot = 3'd3; q_answer = 1'b0;
        tick;
        spawn_req = 1'b0;
        cx = m_lfsr[5:0]; cy = m_lfsr[11:6];
        tick;
        spawn_req = 1'b1; spawn_slot = 3'd4;
        tick;
        spawn_req = 1'b0;
        exp_ax[23:18] = cx; exp_ay[23:18] = cy;
        n_cmp++; if ({busy, done, fail} !== 3'b010) begin n_fail++; $display("FAIL ign_c3_flags: got %b want 010", {busy, done, fail}); end
        tick;
        n_cmp++; if ({busy, done, fail} !== 3'b000) begin n_fail++; $display("FAIL ign_c4_flags: got %b want 000", {busy, done, fail}); end
        n_cmp++; if ({apple_x, apple_y} !== {exp_ax, exp_ay}) begin n_fail++; $display("FAIL ign_apples: got %h/%h want %h/%h", apple_x, apple_y, exp_ax, exp_ay); end
    endtask

    task automatic test_back_to_back;
        logic [5:0] cx, cy;
        spawn_req = 1'b1; spawn_slot = 3'd4; q_answer = 1'b0;
        tick;
        spawn_req = 1'b0;
        cx = m_lfsr[5:0]; cy = m_lfsr[11:6];
        repeat (2) tick;
        exp_ax[29:24] = cx; exp_ay[29:24] = cy;
        n_cmp++; if ({busy, done, fail} !== 3'b010) begin n_fail++; $display("FAIL b2b_first_done: got %b want 010", {busy, done, fail}); end
        spawn_req = 1'b1; spawn_slot = 3'd1;
        tick;
        spawn_req = 1'b0;
        cx = m_lfsr[5:0]; cy = m_lfsr[11:6];
        n_cmp++; if ({busy, done, fail} !== 3'b100) begin n_fail++; $display("FAIL b2b_accept: got %b want 100", {busy, done, fail}); end
        repeat (2) tick;
        exp_ax[11:6] = cx; exp_ay[11:6] = cy;
        n_cmp++; if ({busy, done, fail} !== 3'b010) begin n_fail++; $display("FAIL b2b_second_done: got %b want 010", {busy, done, fail}); end
        n_cmp++; if ({apple_x, apple_y} !== {exp_ax, exp_ay}) begin n_fail++; $display("FAIL b2b_apples: got %h/%h want %h/%h", apple_x, apple_y, exp_ax, exp_ay); end
    endtask

    task automatic test_reset_mid;
        spawn_req = 1'b1; spawn_slot = 3'd0; q_answer = 1'b0;
        tick;
        spawn_req = 1'b0;
        tick;
        rst_n = 1'b0;
        #1;
        exp_ax = '0; exp_ay = '0;
        n_cmp++; if ({busy, done, fail} !== 3'b000) begin n_fail++; $display("FAIL rmid_flags: got %b want 000", {busy, done, fail}); end
        n_cmp++; if ({apple_x, apple_y, q_x, q_y} !== 72'd0) begin n_fail++; $display("FAIL rmid_clear: got %h/%h want 0", apple_x, apple_y); end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        n_cmp++; if ({busy, done, fail} !== 3'b000) begin n_fail++; $display("FAIL rmid_after: got %b want 000", {busy, done, fail}); end
        n_cmp++; if ({apple_x, apple_y} !== 60'd0) begin n_fail++; $display("FAIL rmid_apples: got %h/%h want 0", apple_x, apple_y); end
    endtask

    task automatic test_stats;
`ifdef APPLE_SPAWN_STATS_EN
        n_cmp++; if (spawn_count !== 16'd0) begin n_fail++; $display("FAIL stats_zero: got %0d want 0", spawn_count); end
`endif
        do_success(0);
        do_success(1);
        do_success(2);
`ifdef APPLE_SPAWN_STATS_EN
        n_cmp++; if (spawn_count !== 16'd3) begin n_fail++; $display("FAIL stats_three: got %0d want 3", spawn_count); end
`endif
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        exp_ax = '0; exp_ay = '0;
        rst_n = 1'b0; spawn_req = 1'b0; spawn_slot = 3'd0; q_answer = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset;
        test_single_try;
        test_retry;
        test_exhaust;
        test_bad_slot;
        test_ignore_busy;
        test_back_to_back;
        test_reset_mid;
        test_stats;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apple_spawner.md
APPLE_SPAWNER -- requirements
Module: apple_spawner

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 64, the maximum number of candidate positions tried per spawn (1..255).
REQ-002 SHALL have parameter LFSR_SEED, default 16'hACE1, the nonzero LFSR reset value.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset, as listed below.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 spawn_req  input  1  request to place a new apple; sampled only when idle.
REQ-007 spawn_slot  input  3  apple slot index to overwrite, valid 0..4.
REQ-008 q_x, q_y  output  6 each  registered cell coordinate presented to the occupancy-inquiry block.
REQ-009 q_answer  input  1  combinational inquiry result for (q_x,q_y): 1 = wall, snake or apple, 0 = free.
REQ-010 apple_x, apple_y  output  30 each  packed apple coordinates; slot i occupies bits [i*6+5:i*6].
REQ-011 busy  output  1  high when state is not IDLE.
REQ-012 done  output  1  one-cycle pulse: requested slot has been written.
REQ-013 fail  output  1  one-cycle pulse: request rejected or tries exhausted.

Function
REQ-014 SHALL implement states IDLE, PROPOSE and CHECK; busy = (state != IDLE).
REQ-015 IDLE: spawn_req=1 with spawn_slot<5 -> latch slot, tries=0, go to PROPOSE; spawn_slot>=5 -> fail=1 next cycle, stay in IDLE, no apple change.
REQ-016 PROPOSE: q_x<=lfsr[5:0], q_y<=lfsr[11:6], tries<=tries+1, go to CHECK.
REQ-017 CHECK: q_answer=0 -> write q_x/q_y into the latched slot, done=1 next cycle, go to IDLE.
REQ-018 CHECK: q_answer=1 and tries==MAX_TRIES -> fail=1 next cycle, go to IDLE, apples unchanged; otherwise go to PROPOSE.
REQ-019 Latency: with req sampled at the end of cycle 0, success on try k gives done in cycle 2k+1; exhaustion gives fail in cycle 2*MAX_TRIES+1.
REQ-020 Out-of-range candidates (x=0, x>=63, y=0, y>=47) SHALL NOT be filtered locally; they are rejected via q_answer.
REQ-021 The candidate at the slot's own current position SHALL count as occupied (inquiry reports it) and is retried.
REQ-022 spawn_req while busy SHALL be ignored and not queued; a request in the done/fail cycle SHALL be accepted.
REQ-023 done and fail SHALL never be high in the same cycle.
REQ-024 The LFSR SHALL be 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, and SHALL advance every cycle regardless of state.
REQ-025 tries counter width SHALL be 8 bits; it SHALL not wrap.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, lfsr=LFSR_SEED, q_x=q_y=0, apple_x=apple_y=0 (all slots parked in the wall), tries=0, done=fail=busy=0.
REQ-027 Reset asserted mid-spawn SHALL abort it with no done/fail pulse and no slot write.

Configuration
REQ-028 Macro APPLE_SPAWN_STATS_EN defined -> add output spawn_count [15:0], reset to 0, incremented on each done and wrapping 16'hFFFF->0.
REQ-029 Macro APPLE_SPAWN_STATS_EN undefined -> no spawn_count port and no counter logic; all other behaviour identical.

Structure
REQ-030 Shared package snake_pkg SHALL hold COORD_W=6, GRID_W=64, GRID_H=48, NUM_APPLES=5 and the spawner state enum.
REQ-031 The LFSR SHALL be a sub-module spawn_lfsr (ports clk, rst_n, value[15:0], parameter SEED).

Verification
REQ-032 Reset: after rst_n release, apple_x=apple_y=0, busy=0, done=fail=0, q_x=q_y=0.
REQ-033 q_answer tied 0, spawn_req with slot 2 in cycle 0 -> busy in cycles 1-2, done in cycle 3, apple_x[17:12]/apple_y[17:12] equal the q_x/q_y of cycle 2, other slots unchanged.
REQ-034 q_answer=1 for the first two CHECKs then 0, slot 0 -> done in cycle 7, slot 0 holds the third candidate.
REQ-035 MAX_TRIES=4, q_answer tied 1 -> fail in cycle 9, apples unchanged; spawn_slot=6 -> fail in cycle 1, busy never high.
REQ-036 spawn_req pulsed again in cycle 2 -> ignored; rst_n low during CHECK -> no done, apples zero; with APPLE_SPAWN_STATS_EN, three successes -> spawn_count=3.
